// File: rtl/bus_decoder_n.sv
// Parametrised N-slave CPU bus decoder: region-based read/write routing with a
// variable-latency read handshake, read timeout and sticky error capture.
module bus_decoder_n #(
  parameter int                   NSLAVES   = 3,
  parameter logic [NSLAVES*4-1:0] SLAVE_IDS = {4'd2, 4'd1, 4'd0},
  parameter int                   TIMEOUT   = 64,
  parameter logic [31:0]          ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_ren,
  input  logic [31:0]          cpu_raddr,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_rvalid,
  output logic                 cpu_rerr,
  input  logic                 cpu_wen,
  input  logic [31:0]          cpu_waddr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_bytemask,
  output logic                 cpu_werr,
  output logic                 cpu_stall,
  output logic [NSLAVES-1:0]   s_ren,
  output logic [31:0]          s_raddr,
  input  logic [NSLAVES*32-1:0] s_rdata,
  input  logic [NSLAVES-1:0]   s_rvalid,
  output logic [NSLAVES-1:0]   s_wen,
  output logic [31:0]          s_waddr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_bytemask,
  output logic                 err_valid,
  output logic [31:0]          err_addr,
  output logic                 err_is_write,
  input  logic                 err_clr
);

  localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, PEND, RERR} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_raddr;
  logic             r_werr;
  logic             r_err_valid;
  logic [31:0]      r_err_addr;
  logic             r_err_is_write;

  logic             w_rhit, w_whit;
  logic [SEL_W-1:0] w_rsel, w_wsel;
  logic             w_stall, w_accept, w_racc, w_wacc;
  logic             w_pend_valid, w_timeout;
  logic             w_rd_err, w_wr_err;
  logic [31:0]      w_rd_err_addr;

  // Lowest-index match wins: scan from the top so lower indices overwrite.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_rhit = 1'b0;
    w_rsel = '0;
    w_whit = 1'b0;
    w_wsel = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (cpu_raddr[31:28] == SLAVE_IDS[i*4 +: 4]) begin
        w_rhit = 1'b1;
        w_rsel = SEL_W'(i);
      end
      if (cpu_waddr[31:28] == SLAVE_IDS[i*4 +: 4]) begin
        w_whit = 1'b1;
        w_wsel = SEL_W'(i);
      end
    end
  end

  assign w_pend_valid = (r_state == PEND) && s_rvalid[r_sel];
  assign w_stall      = (r_state == PEND) && !s_rvalid[r_sel];
  assign w_timeout    = (TIMEOUT > 0) && w_stall && (r_cnt == CNT_LAST);
  assign w_accept     = !w_stall;
  assign w_racc       = w_accept && cpu_ren;
  assign w_wacc       = w_accept && cpu_wen;

  // A timeout only happens while stalled, so it never coincides with a new read.
  assign w_rd_err      = (w_racc && !w_rhit) || w_timeout;
  assign w_rd_err_addr = w_timeout ? r_raddr : cpu_raddr;
  assign w_wr_err      = w_wacc && !w_whit;

  assign s_raddr    = cpu_raddr;
  assign s_waddr    = cpu_waddr;
  assign s_wdata    = cpu_wdata;
  assign s_bytemask = cpu_bytemask;

  // Combinational strobes are gated by rst_n so nothing leaks out while reset is held.
  assign s_ren      = (rst_n && w_racc && w_rhit) ? (NSLAVES'(1) << w_rsel) : '0;
  assign s_wen      = (rst_n && w_wacc && w_whit) ? (NSLAVES'(1) << w_wsel) : '0;
  assign cpu_stall  = rst_n && w_stall;
  assign cpu_rvalid = rst_n && ((r_state == RERR) || w_pend_valid);
  assign cpu_rerr   = rst_n && (r_state == RERR);
  assign cpu_werr   = r_werr;

  always_comb begin
    cpu_rdata = '0;
    if (rst_n && r_state == RERR)
      cpu_rdata = ERR_DATA;
    else if (rst_n && w_pend_valid)
      cpu_rdata = s_rdata[r_sel*32 +: 32];
  end

  assign err_valid    = r_err_valid;
  assign err_addr     = r_err_addr;
  assign err_is_write = r_err_is_write;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous by design.
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_werr         <= 1'b0;
      r_err_valid    <= 1'b0;
      r_err_addr     <= '0;
      r_err_is_write <= 1'b0;
    end else begin
      r_werr <= w_wr_err;
      if (w_accept) begin
        if (cpu_ren && w_rhit) begin
          r_state <= PEND;
          r_cnt   <= '0;
        end else if (cpu_ren) begin
          r_state <= RERR;
        end else begin
          r_state <= IDLE;
        end
      end else if (w_timeout) begin
        r_state <= RERR;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A new error wins over a same-cycle clear; a read error wins over a write error.
      if ((w_rd_err || w_wr_err) && (!r_err_valid || err_clr)) begin
        r_err_valid    <= 1'b1;
        r_err_addr     <= w_rd_err ? w_rd_err_addr : cpu_waddr;
        r_err_is_write <= !w_rd_err;
      end else if (err_clr) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  // NOTE: slave select and read address are datapath only, qualified by r_state, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_racc && w_rhit) begin
      r_sel   <= w_rsel;
      r_raddr <= cpu_raddr;
    end
  end

endmodule

// File: tb/tb_bus_decoder_n.sv
// Self-checking bench for bus_decoder_n: default instance plus a TIMEOUT=4 instance on shared inputs.
module tb_bus_decoder_n;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_ren, cpu_wen, err_clr;
  logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata;
  logic [3:0]  cpu_bytemask;
  logic [95:0] s_rdata;
  logic [2:0]  s_rvalid;

  logic [31:0] a_rdata, a_s_raddr, a_s_waddr, a_s_wdata, a_err_addr;
  logic        a_rvalid, a_rerr, a_werr, a_stall, a_err_valid, a_err_is_write;
  logic [2:0]  a_s_ren, a_s_wen;
  logic [3:0]  a_s_bytemask;

  logic [31:0] b_rdata, b_s_raddr, b_s_waddr, b_s_wdata, b_err_addr;
  logic        b_rvalid, b_rerr, b_werr, b_stall, b_err_valid, b_err_is_write;
  logic [2:0]  b_s_ren, b_s_wen;
  logic [3:0]  b_s_bytemask;

  int   total = 0;
  int   bad   = 0;
  bit   mon_b = 1'b0;
  rsp_t exp_q[$];

  logic [31:0] smp_rdata, smp_err_addr, smp_waddr;
  logic        smp_rvalid, smp_rerr, smp_werr, smp_stall, smp_err_valid, smp_err_is_write;
  logic [2:0]  smp_sren, smp_swen;
  logic [3:0]  smp_bmask;

  bus_decoder_n dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rdata(a_rdata),
    .cpu_rvalid(a_rvalid), .cpu_rerr(a_rerr),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_bytemask(cpu_bytemask), .cpu_werr(a_werr), .cpu_stall(a_stall),
    .s_ren(a_s_ren), .s_raddr(a_s_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_wen(a_s_wen), .s_waddr(a_s_waddr), .s_wdata(a_s_wdata), .s_bytemask(a_s_bytemask),
    .err_valid(a_err_valid), .err_addr(a_err_addr), .err_is_write(a_err_is_write),
    .err_clr(err_clr)
  );

  bus_decoder_n #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rdata(b_rdata),
    .cpu_rvalid(b_rvalid), .cpu_rerr(b_rerr),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_bytemask(cpu_bytemask), .cpu_werr(b_werr), .cpu_stall(b_stall),
    .s_ren(b_s_ren), .s_raddr(b_s_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_wen(b_s_wen), .s_waddr(b_s_waddr), .s_wdata(b_s_wdata), .s_bytemask(b_s_bytemask),
    .err_valid(b_err_valid), .err_addr(b_err_addr), .err_is_write(b_err_is_write),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One bus cycle: sample the monitored DUT at negedge, score any read response, then step past posedge.
  task automatic cycle();
    rsp_t e;
    @(negedge clk);
    if (mon_b) begin
      smp_rdata = b_rdata; smp_rvalid = b_rvalid; smp_rerr = b_rerr; smp_werr = b_werr;
      smp_stall = b_stall; smp_sren = b_s_ren; smp_swen = b_s_wen; smp_err_valid = b_err_valid;
      smp_err_addr = b_err_addr; smp_err_is_write = b_err_is_write;
      smp_waddr = b_s_waddr; smp_bmask = b_s_bytemask;
    end else begin
      smp_rdata = a_rdata; smp_rvalid = a_rvalid; smp_rerr = a_rerr; smp_werr = a_werr;
      smp_stall = a_stall; smp_sren = a_s_ren; smp_swen = a_s_wen; smp_err_valid = a_err_valid;
      smp_err_addr = a_err_addr; smp_err_is_write = a_err_is_write;
      smp_waddr = a_s_waddr; smp_bmask = a_s_bytemask;
    end
    if (smp_rvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: rvalid=1 rdata=%h rerr=%b, required no response", smp_rdata, smp_rerr);
      end else begin
        e = exp_q.pop_front();
        if ({smp_rdata, smp_rerr} !== {e.data, e.err}) begin
          bad++;
          $display("FAIL sb_rsp: rdata=%h rerr=%b, required rdata=%h rerr=%b", smp_rdata, smp_rerr, e.data, e.err);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_ren = 0; cpu_wen = 0; err_clr = 0; s_rvalid = '0;
    cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0; cpu_bytemask = '0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  task automatic sb_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; cpu_ren = 1; cpu_raddr = 32'h0000_0000; cpu_wen = 1; cpu_waddr = 32'h1000_0000;
    cycle();
    total++;
    if ({smp_sren, smp_swen, smp_rvalid, smp_stall} !== 8'b0) begin
      bad++;
      $display("FAIL reset_hold: sren=%b swen=%b rvalid=%b stall=%b, required all 0",
               smp_sren, smp_swen, smp_rvalid, smp_stall);
    end
    idle_inputs(); rst_n = 1;
    cycle();
    total++;
    if ({smp_err_valid, smp_err_addr, smp_err_is_write, smp_werr, smp_rerr} !== 36'b0) begin
      bad++;
      $display("FAIL reset_state: err_valid=%b err_addr=%h is_write=%b werr=%b rerr=%b, required 0",
               smp_err_valid, smp_err_addr, smp_err_is_write, smp_werr, smp_rerr);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    do_reset();
    cpu_ren = 1; cpu_raddr = 32'h0000_0010;
    exp_q.push_back('{data: 32'h11, err: 1'b0});
    cycle(); stalls += int'(smp_stall);
    total++;
    if (smp_sren !== 3'b001) begin bad++; $display("FAIL b2b_sren0: got %b, required 001", smp_sren); end
    cpu_raddr = 32'h1000_0020; s_rvalid = 3'b001; s_rdata[31:0] = 32'h11;
    exp_q.push_back('{data: 32'h22, err: 1'b0});
    cycle(); stalls += int'(smp_stall);
    total++;
    if (smp_sren !== 3'b010 || smp_rvalid !== 1'b1) begin
      bad++; $display("FAIL b2b_second: sren=%b rvalid=%b, required 010 and 1", smp_sren, smp_rvalid);
    end
    cpu_ren = 0; s_rvalid = 3'b010; s_rdata[63:32] = 32'h22;
    cycle(); stalls += int'(smp_stall);
    total++;
    if (smp_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_third: rvalid=%b, required 1", smp_rvalid); end
    s_rvalid = '0;
    cycle(); stalls += int'(smp_stall);
    total++;
    if (stalls != 0) begin bad++; $display("FAIL b2b_stall: %0d stall cycles, required 0", stalls); end
    sb_drained("b2b");
  endtask

  task automatic test_slow_slave();
    int stalls = 0;
    int pulses = 0;
    do_reset();
    cpu_ren = 1; cpu_raddr = 32'h2000_0000;
    cycle(); pulses += int'(smp_sren[2]);
    cpu_ren = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); stalls += int'(smp_stall); pulses += int'(smp_sren[2]);
    end
    total++;
    if (stalls != 4) begin bad++; $display("FAIL slow_stall: %0d stall cycles, required 4", stalls); end
    s_rvalid = 3'b100; s_rdata[95:64] = 32'hA5;
    exp_q.push_back('{data: 32'hA5, err: 1'b0});
    cycle(); pulses += int'(smp_sren[2]);
    total++;
    if (smp_stall !== 1'b0 || smp_rvalid !== 1'b1) begin
      bad++; $display("FAIL slow_resp: stall=%b rvalid=%b, required 0 and 1", smp_stall, smp_rvalid);
    end
    s_rvalid = '0;
    cycle(); pulses += int'(smp_sren[2]);
    total++;
    if (pulses != 1) begin bad++; $display("FAIL slow_sren: %0d s_ren[2] pulses, required 1", pulses); end
    sb_drained("slow");
  endtask

  task automatic test_unmapped_read();
    do_reset();
    cpu_ren = 1; cpu_raddr = 32'hF000_0004;
    cycle();
    total++;
    if (smp_sren !== 3'b000 || smp_rvalid !== 1'b0) begin
      bad++; $display("FAIL unmap_accept: sren=%b rvalid=%b, required 000 and 0", smp_sren, smp_rvalid);
    end
    cpu_ren = 0;
    exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    cycle();
    total++;
    if ({smp_err_valid, smp_err_addr, smp_err_is_write} !== {1'b1, 32'hF000_0004, 1'b0}) begin
      bad++; $display("FAIL unmap_capture: err_valid=%b addr=%h is_write=%b, required 1 f0000004 0",
                      smp_err_valid, smp_err_addr, smp_err_is_write);
    end
    sb_drained("unmap");
  endtask

  task automatic test_timeout();
    int stalls = 0;
    mon_b = 1'b1;
    do_reset();
    cpu_ren = 1; cpu_raddr = 32'h0000_0040;
    cycle();
    total++;
    if (smp_sren !== 3'b001) begin bad++; $display("FAIL tmo_sren: got %b, required 001", smp_sren); end
    cpu_ren = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); stalls += int'(smp_stall);
    end
    total++;
    if (stalls != 4) begin bad++; $display("FAIL tmo_stall: %0d stall cycles, required 4", stalls); end
    exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    cycle();
    total++;
    if ({smp_stall, smp_err_valid, smp_err_addr, smp_err_is_write} !== {1'b0, 1'b1, 32'h0000_0040, 1'b0}) begin
      bad++; $display("FAIL tmo_capture: stall=%b err_valid=%b addr=%h is_write=%b, required 0 1 00000040 0",
                      smp_stall, smp_err_valid, smp_err_addr, smp_err_is_write);
    end
    s_rvalid = 3'b001; s_rdata[31:0] = 32'h77;
    cycle();
    total++;
    if (smp_rvalid !== 1'b0) begin bad++; $display("FAIL tmo_late: rvalid=%b, required 0", smp_rvalid); end
    s_rvalid = '0;
    sb_drained("tmo");
    mon_b = 1'b0;
  endtask

  task automatic test_write();
    do_reset();
    cpu_wen = 1; cpu_waddr = 32'h0000_0008; cpu_wdata = 32'hCAFE_0001; cpu_bytemask = 4'b0011;
    cycle();
    total++;
    if ({smp_swen, smp_bmask, smp_waddr} !== {3'b001, 4'b0011, 32'h0000_0008}) begin
      bad++; $display("FAIL wr_hit: swen=%b bmask=%b waddr=%h, required 001 0011 00000008",
                      smp_swen, smp_bmask, smp_waddr);
    end
    cpu_waddr = 32'h7000_0000;
    cycle();
    total++;
    if (smp_swen !== 3'b000 || smp_werr !== 1'b0) begin
      bad++; $display("FAIL wr_miss: swen=%b werr=%b, required 000 and 0", smp_swen, smp_werr);
    end
    cpu_wen = 0;
    cycle();
    total++;
    if ({smp_werr, smp_err_valid, smp_err_addr, smp_err_is_write} !== {1'b1, 1'b1, 32'h7000_0000, 1'b1}) begin
      bad++; $display("FAIL wr_err1: werr=%b err_valid=%b addr=%h is_write=%b, required 1 1 70000000 1",
                      smp_werr, smp_err_valid, smp_err_addr, smp_err_is_write);
    end
    cpu_wen = 1; cpu_waddr = 32'h9000_0000;
    cycle();
    cpu_wen = 0;
    cycle();
    total++;
    if ({smp_werr, smp_err_addr} !== {1'b1, 32'h7000_0000}) begin
      bad++; $display("FAIL wr_sticky: werr=%b addr=%h, required 1 70000000", smp_werr, smp_err_addr);
    end
    cpu_wen = 1; cpu_waddr = 32'hA000_0000; err_clr = 1;
    cycle();
    cpu_wen = 0; err_clr = 0;
    cycle();
    total++;
    if ({smp_err_valid, smp_err_addr} !== {1'b1, 32'hA000_0000}) begin
      bad++; $display("FAIL wr_clr_new: err_valid=%b addr=%h, required 1 a0000000", smp_err_valid, smp_err_addr);
    end
    err_clr = 1;
    cycle();
    err_clr = 0;
    cycle();
    total++;
    if (smp_err_valid !== 1'b0) begin bad++; $display("FAIL wr_clr: err_valid=%b, required 0", smp_err_valid); end
    cpu_ren = 1; cpu_raddr = 32'hF000_0100; cpu_wen = 1; cpu_waddr = 32'hE000_0200;
    exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    cycle();
    cpu_ren = 0; cpu_wen = 0;
    cycle();
    total++;
    if ({smp_werr, smp_err_addr, smp_err_is_write} !== {1'b1, 32'hF000_0100, 1'b0}) begin
      bad++; $display("FAIL wr_rd_prio: werr=%b addr=%h is_write=%b, required 1 f0000100 0",
                      smp_werr, smp_err_addr, smp_err_is_write);
    end
    sb_drained("wr");
  endtask

  task automatic test_reset_mid_pend();
    do_reset();
    cpu_ren = 1; cpu_raddr = 32'hF000_0000;
    exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    cycle();
    cpu_raddr = 32'h2000_0010;
    cycle();
    cpu_ren = 0;
    cycle();
    total++;
    if (smp_stall !== 1'b1 || smp_err_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre: stall=%b err_valid=%b, required 1 and 1", smp_stall, smp_err_valid);
    end
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    total++;
    if (smp_stall !== 1'b0 || smp_err_valid !== 1'b0) begin
      bad++; $display("FAIL rst_post: stall=%b err_valid=%b, required 0 and 0", smp_stall, smp_err_valid);
    end
    s_rvalid = 3'b100; s_rdata[95:64] = 32'h5A;
    cycle();
    total++;
    if (smp_rvalid !== 1'b0) begin bad++; $display("FAIL rst_late: rvalid=%b, required 0", smp_rvalid); end
    s_rvalid = '0;
    sb_drained("rst");
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_back_to_back();
    test_slow_slave();
    test_unmapped_read();
    test_timeout();
    test_write();
    test_reset_mid_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
